ps2_device_tx: RTL
==================

# ps2_device_tx

Simulation- and board-side PS/2 device transmitter: the keyboard end of the PS/2 link whose host-side receiver is `ps2_keyboard`. It accepts scan-code bytes through a valid/ready port, buffers them in a small FIFO, and serialises each byte as an 11-bit PS/2 frame on generated `ps2_clk`/`ps2_data` lines. It sits beside `ps2_keyboard` in `top`, or drives it directly in the bench, for loopback of scan codes without a physical keyboard. Device-to-host only; host-to-device commands and inhibit are out of scope.

## Interface
- `CLK_HALF`, 50: system cycles per `ps2_clk` half-period (≥2).
- `GAP_HALVES`, 4: idle half-periods between consecutive frames (≥1).
- `FIFO_DEPTH`, 8: byte FIFO entries (power of 2).

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: `in_data` presented for enqueue.
- `in_data` in 8: scan-code byte.
- `in_ready` out 1: FIFO not full (from registered count).
- `ps2_clk` out 1: generated PS/2 clock, registered.
- `ps2_data` out 1: PS/2 data, registered.
- `busy` out 1: FSM not in IDLE.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when `in_valid && !in_ready`.

## Operation
- Reset (async): `ps2_clk`=1, `ps2_data`=1, `busy`=0, `fifo_count`=0, `overflow`=0, `in_ready`=1, FSM=IDLE, dividers cleared; any in-flight frame is abandoned.
- Enqueue: `in_valid && in_ready` on an edge writes `in_data`. `in_valid && !in_ready` drops the byte and sets `overflow` (cleared only by `rst`).
- Simultaneous push and pop: both occur; count unchanged. When full, `in_ready`=0 even if a pop happens that cycle.
- Frame: bit 0 start = 0; bits 1–8 = data LSB first; bit 9 = odd parity (`~^data`); bit 10 stop = 1.
- FSM states:
  - IDLE: lines high. If `fifo_count`>0, pop the head into the shift register, drive `ps2_data` = start bit, go to SEND with bit index 0.
  - SEND: each bit lasts 2·`CLK_HALF` cycles: `ps2_clk` high for `CLK_HALF`, then low for `CLK_HALF`. `ps2_data` changes only at the start of the high phase. After bit 10's low phase, go to GAP.
  - GAP: `ps2_clk`=1, `ps2_data`=1 for `GAP_HALVES`·`CLK_HALF` cycles, then IDLE.
- The receiver samples on `ps2_clk` falling edges. Data is stable `CLK_HALF` cycles before and after each fall.

## Timing
- Push at edge E into an empty FIFO while IDLE: pop and `ps2_data`→0 at edge E+1. `ps2_clk` first falls at edge E+1+`CLK_HALF`.
- Frame length: 22·`CLK_HALF` cycles, from `ps2_data` falling to the last `ps2_clk` rising edge. Frame-to-frame start spacing: (22+`GAP_HALVES`)·`CLK_HALF` cycles.
- Exactly 11 falling edges of `ps2_clk` per frame. None occur in IDLE or GAP.
- `busy` goes 1 at the pop edge and 0 on the edge that returns the FSM to IDLE.
- `fifo_count`/`in_ready` update on the edge after push/pop.

## Test plan
- Single byte 0x1C with default parameters: on successive `ps2_clk` falls, `ps2_data` = 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. Frame occupies 1100 cycles; `busy` drops 200 cycles later.
- Parity corners: 0x00 gives parity 1; 0x01 gives 0; 0xFF gives 1. Each frame has 11 falls, and the stop bit is 1.
- Burst: `in_valid`=1 for 10 consecutive cycles from reset-idle with bytes 0x01–0x0A. Expect 9 bytes accepted and 0x0A dropped, `overflow`=1, `fifo_count` peaking at 8. Nine frames are emitted in order, each start spaced 1300 cycles apart.
- Loopback into `ps2_keyboard` with `CLK_HALF`=50: send 0x1C, 0xF0, 0x1C. The receiver reports the same three bytes with no parity error.
- Async reset asserted mid-frame (after 5th fall), without waiting for a clock edge: `ps2_clk`=`ps2_data`=1, `busy`=0, `fifo_count`=0, `overflow`=0. After release with FIFO empty, no further falls occur.
- Simultaneous push and pop at full, and at count 3: at full, the push is refused and `overflow` is set. At count 3, the count stays 3 and the FIFO order is preserved.

Source files
------------

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: FIFO-buffered PS/2 device-side transmitter; clk/rst (async high), in_valid/in_data/in_ready push port, ps2_clk/ps2_data lines, busy/fifo_count/overflow status
module ps2_device_tx #(
  parameter int CLK_HALF   = 50,
  parameter int GAP_HALVES = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_HALF);
  localparam int HW = GAP_HALVES > 1 ? $clog2(GAP_HALVES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] div;
  logic [HW-1:0] half;
  logic [3:0]    bit_idx;
  logic [9:0]    shreg;
  logic [7:0]    head;
  logic          push, pop, half_end, gap_end;
  assign in_ready   = count != CW'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign half_end   = div == DW'(CLK_HALF - 1);
  assign gap_end    = state == GAP && half_end && half == HW'(GAP_HALVES - 1);
  // the gap hands straight over to the next frame so back-to-back starts stay evenly spaced
  assign pop        = count != '0 && (state == IDLE || gap_end);
  assign head       = mem[rd_ptr];
  assign busy       = state != IDLE;
  assign fifo_count = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      div      <= '0;
      half     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (pop) begin
      state    <= SEND;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b0;
      div      <= '0;
      bit_idx  <= '0;
      shreg    <= {1'b1, ~^head, head};
    end else if (state != IDLE) begin
      div <= half_end ? '0 : div + 1'b1;
      if (state == SEND && half_end) begin
        ps2_clk <= !ps2_clk;
        // rising edge of ps2_clk: advance to the next bit
        if (!ps2_clk) begin
          ps2_data <= shreg[0];
          shreg    <= shreg >> 1;
          bit_idx  <= bit_idx + 1'b1;
          if (bit_idx == 4'd10) begin
            state    <= GAP;
            half     <= '0;
            ps2_data <= 1'b1;
          end
        end
      end
      if (state == GAP && half_end) begin
        half <= half + 1'b1;
        if (gap_end) state <= IDLE;
      end
    end
endmodule
